mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port 256x16 synchronous RAM between the CPU's load/fetch path (requester 0) and the host loader/debug port (requester 1). Accepts one access at a time, sequences it onto the RAM port, and returns read data with a completion pulse. Sits between the CPU memory interface and the RAM instance in the top level. Arbitration is round-robin, so neither side starves.

---
 rtl/arb_pkg.sv | 16 +
 rtl/rr_pick2.sv | 15 +
 rtl/mem_arbiter.sv | 98 +++++++++
 tb/tb_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared widths, FSM encoding and requester indices for the RAM arbiter.
package arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam logic REQ_CPU  = 1'b0;
    localparam logic REQ_HOST = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
// A single request always wins; on a tie the side that did not go last wins.
module rr_pick2
    import arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    assign valid  = |req;
    assign winner = (&req) ? ~last : req[REQ_HOST];

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous single-port RAM between the CPU and the host port.
// Each access takes an ISSUE cycle (grant) and a WAIT cycle (done + read data).
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W = arb_pkg::ADDR_W,
    parameter int DATA_W = arb_pkg::DATA_W
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_done,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_t        r_state;
    logic              r_owner;
    logic              r_last;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic w_valid;
    logic w_winner;
    logic w_issue;
    logic w_wait;

    rr_pick2 u_pick (
        .req    ({host_req, cpu_req}),
        .last   (r_last),
        .valid  (w_valid),
        .winner (w_winner)
    );

    // WAIT arbitrates exactly like IDLE, which gives the two-cycle back-to-back rate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= REQ_CPU;
            r_last  <= REQ_HOST;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                ISSUE: begin
                    r_state <= WAIT;
                    r_last  <= r_owner;
                end
                IDLE, WAIT: begin
                    if (w_valid) begin
                        r_state <= ISSUE;
                        r_owner <= w_winner;
                        r_we    <= w_winner ? host_we    : cpu_we;
                        r_addr  <= w_winner ? host_addr  : cpu_addr;
                        r_wdata <= w_winner ? host_wdata : cpu_wdata;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_issue = (r_state == ISSUE);
    assign w_wait  = (r_state == WAIT);

    assign cpu_gnt   = w_issue && (r_owner == REQ_CPU);
    assign host_gnt  = w_issue && (r_owner == REQ_HOST);
    assign cpu_done  = w_wait && (r_owner == REQ_CPU);
    assign host_done = w_wait && (r_owner == REQ_HOST);

    // Read data is only passed through during the owner's WAIT of a read.
    assign cpu_rdata  = (cpu_done && !r_we)  ? ram_rdata : '0;
    assign host_rdata = (host_done && !r_we) ? ram_rdata : '0;

    assign ram_we    = w_issue && r_we;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter with a behavioural RAM,
// a per-requester expected-access queue and a cycle-level grant/done model.
module tb_mem_arbiter;
    import arb_pkg::*;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0]  cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        host_req = 1'b0, host_we = 1'b0;
    logic [7:0]  host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic        cpu_gnt, cpu_done, host_gnt, host_done, ram_we;
    logic [15:0] cpu_rdata, host_rdata, ram_wdata;
    logic [7:0]  ram_addr;
    logic [15:0] ram_rdata = '0;

    logic [15:0] ramMem [256];
    logic [15:0] refMem [256];
    acc_t        cpuQ[$];
    acc_t        hostQ[$];

    int   errors = 0;
    int   checks = 0;
    logic monitorOn = 1'b0;
    logic [1:0] expGnt = 2'b00;
    logic [1:0] expDone = 2'b00;
    logic lastOwner = 1'b1;

    mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_done   (cpu_done),
        .cpu_rdata  (cpu_rdata),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_gnt   (host_gnt),
        .host_done  (host_done),
        .host_rdata (host_rdata),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] initVal(input int a);
        logic [15:0] v;
        case (a)
            100:     v = 16'd250;
            101:     v = 16'hFE9E;
            102:     v = 16'd345;
            default: v = 16'(a * 37 + 11);
        endcase
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Single-port RAM with one cycle of read latency.
    initial begin
        forever begin
            @(posedge clk);
            if (ram_we) ramMem[ram_addr] <= ram_wdata;
            ram_rdata <= ramMem[ram_addr];
        end
    end

    task automatic checkGrant(input int side);
        acc_t a;
        if (side == 0 && cpuQ.size() == 0 || side == 1 && hostQ.size() == 0) begin
            checkOutput("grantWithoutRequest", 32'(side), 32'hFFFF);
            return;
        end
        a = (side == 0) ? cpuQ[0] : hostQ[0];
        checkOutput("ramAddr", 32'(ram_addr), 32'(a.addr));
        checkOutput("ramWe", 32'(ram_we), 32'(a.we));
        if (a.we) checkOutput("ramWdata", 32'(ram_wdata), 32'(a.wdata));
    endtask

    task automatic checkDone(input int side, input logic [15:0] rdata);
        acc_t a;
        if (side == 0 && cpuQ.size() == 0 || side == 1 && hostQ.size() == 0) begin
            checkOutput("doneWithoutRequest", 32'(side), 32'hFFFF);
            return;
        end
        if (side == 0) a = cpuQ.pop_front();
        else           a = hostQ.pop_front();
        if (a.we) begin
            refMem[a.addr] = a.wdata;
            checkOutput("rdataOnWrite", 32'(rdata), 32'h0);
        end else begin
            checkOutput(side == 0 ? "cpuRdata" : "hostRdata", 32'(rdata), 32'(refMem[a.addr]));
        end
    endtask

    // Monitor: compares every cycle against the model, then predicts the next cycle.
    initial begin
        logic [1:0] gntV;
        logic [1:0] doneV;
        logic [1:0] reqV;
        forever begin
            @(negedge clk);
            if (monitorOn && !rst) begin
                gntV  = {host_gnt, cpu_gnt};
                doneV = {host_done, cpu_done};
                reqV  = {host_req, cpu_req};
                checkOutput("gntVector", 32'(gntV), 32'(expGnt));
                checkOutput("doneVector", 32'(doneV), 32'(expDone));
                if (gntV == 2'b00) checkOutput("weOutsideIssue", 32'(ram_we), 32'h0);
                if (cpu_gnt)  checkGrant(0);
                if (host_gnt) checkGrant(1);
                if (cpu_done) checkDone(0, cpu_rdata);
                else          checkOutput("cpuRdataIdle", 32'(cpu_rdata), 32'h0);
                if (host_done) checkDone(1, host_rdata);
                else           checkOutput("hostRdataIdle", 32'(host_rdata), 32'h0);

                if (expGnt != 2'b00) begin
                    expDone = expGnt;
                    expGnt  = 2'b00;
                end else begin
                    expDone = 2'b00;
                    if (reqV == 2'b11) expGnt = lastOwner ? 2'b01 : 2'b10;
                    else               expGnt = reqV;
                    if (expGnt != 2'b00) lastOwner = expGnt[1];
                end
            end
        end
    end

    // Raise a request, hold it until granted, then release it on the next edge.
    task automatic applyStimulus(input int side, input logic we, input logic [7:0] addr,
                                 input logic [15:0] wdata);
        acc_t a;
        logic got;
        a = '{we: we, addr: addr, wdata: wdata};
        if (side == 0) begin
            cpuQ.push_back(a);
            cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        end else begin
            hostQ.push_back(a);
            host_we = we; host_addr = addr; host_wdata = wdata; host_req = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = (side == 0) ? cpu_gnt : host_gnt;
        end
        checkOutput("grantTimeout", 32'(got), 32'h1);
        @(posedge clk);
        #1;
        if (side == 0) cpu_req = 1'b0;
        else           host_req = 1'b0;
    endtask

    task automatic waitIdle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic resetModel();
        cpuQ.delete();
        hostQ.delete();
        expGnt    = 2'b00;
        expDone   = 2'b00;
        lastOwner = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic got;
        for (int i = 0; i < 256; i++) begin
            ramMem[i] = initVal(i);
            refMem[i] = initVal(i);
        end

        #1 rst = 1'b1;
        #2;
        checkOutput("rstCpuGnt", 32'(cpu_gnt), 32'h0);
        checkOutput("rstHostGnt", 32'(host_gnt), 32'h0);
        checkOutput("rstCpuDone", 32'(cpu_done), 32'h0);
        checkOutput("rstHostDone", 32'(host_done), 32'h0);
        checkOutput("rstRamWe", 32'(ram_we), 32'h0);
        checkOutput("rstRamAddr", 32'(ram_addr), 32'h0);
        checkOutput("rstRamWdata", 32'(ram_wdata), 32'h0);
        checkOutput("rstCpuRdata", 32'(cpu_rdata), 32'h0);
        checkOutput("rstHostRdata", 32'(host_rdata), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        resetModel();
        monitorOn = 1'b1;

        $display("[TB] single CPU read");
        applyStimulus(0, 1'b0, 8'd100, 16'h0);
        waitIdle(3);

        $display("[TB] simultaneous requests");
        fork
            applyStimulus(0, 1'b0, 8'd101, 16'h0);
            applyStimulus(1, 1'b0, 8'd102, 16'h0);
        join
        waitIdle(3);

        $display("[TB] host write then CPU read");
        applyStimulus(1, 1'b1, 8'd103, 16'd534);
        applyStimulus(0, 1'b0, 8'd103, 16'h0);
        waitIdle(3);

        $display("[TB] back-to-back CPU reads");
        applyStimulus(0, 1'b0, 8'd100, 16'h0);
        applyStimulus(0, 1'b0, 8'd101, 16'h0);
        applyStimulus(0, 1'b0, 8'd102, 16'h0);
        waitIdle(3);

        $display("[TB] both sides saturated");
        fork
            begin
                applyStimulus(0, 1'b0, 8'd100, 16'h0);
                applyStimulus(0, 1'b0, 8'd101, 16'h0);
            end
            begin
                applyStimulus(1, 1'b0, 8'd102, 16'h0);
                applyStimulus(1, 1'b0, 8'd103, 16'h0);
            end
        join
        waitIdle(3);

        $display("[TB] reset during host write issue");
        monitorOn = 1'b0;
        host_we = 1'b1; host_addr = 8'd200; host_wdata = 16'h1234; host_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = host_gnt;
        end
        checkOutput("abortGrantSeen", 32'(got), 32'h1);
        checkOutput("abortWeHigh", 32'(ram_we), 32'h1);
        #1 rst = 1'b1;
        #1;
        checkOutput("abortGntDrop", 32'(host_gnt), 32'h0);
        checkOutput("abortWeDrop", 32'(ram_we), 32'h0);
        host_req = 1'b0;
        @(negedge clk);
        checkOutput("abortNoDone", 32'(host_done), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        resetModel();
        monitorOn = 1'b1;
        applyStimulus(0, 1'b0, 8'd102, 16'h0);
        waitIdle(3);

        $display("[TB] random traffic");
        fork
            for (int n = 0; n < 25; n++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                applyStimulus(0, 1'($urandom_range(0, 1)), 8'(96 + $urandom_range(0, 15)),
                              16'($urandom));
            end
            for (int n = 0; n < 25; n++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                applyStimulus(1, 1'($urandom_range(0, 1)), 8'(96 + $urandom_range(0, 15)),
                              16'($urandom));
            end
        join
        waitIdle(5);

        checkOutput("cpuQueueDrained", 32'(cpuQ.size()), 32'h0);
        checkOutput("hostQueueDrained", 32'(hostQ.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
